// File: rtl/boot_loader.sv
// boot_loader: serial boot loader that sits in front of the CPU core and its
// program RAM. It receives a frame of big-endian 32-bit words, writes them to
// RAM from address 0 upward, then releases the CPU's active-low reset.
//
// Frame: SYNC_BYTE, LEN_HI, LEN_LO, then LEN words of 4 bytes each, MSB first.
//
// Optional feature, enabled by defining BOOT_LOADER_CHECKSUM_EN: a running XOR
// of all data bytes must be matched by one trailing checksum byte. A match
// starts the CPU. A mismatch parks the loader in ERROR.
module boot_loader #(
    parameter int         ADDR_W    = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hC0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [31:0]       cpu_data,
    input  logic              cpu_wren,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_data,
    output logic              ram_wren,
    output logic              cpu_nreset,
    output logic [7:0]        status
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
`ifdef BOOT_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_RUN,
        S_ERROR
    } state_t;

    // Where the frame goes once the last word is written (or LEN was zero).
`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam state_t S_FRAME_END = S_CSUM;
`else
    localparam state_t S_FRAME_END = S_RUN;
`endif

    state_t      state_reg, state_next;
    logic [15:0] len_reg, len_next;
    logic [15:0] index_reg, index_next;
    logic [31:0] word_reg, word_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic        cpu_nreset_reg;
    logic        accept;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]  csum_reg, csum_next;
`endif

    assign accept     = rx_valid && rx_ready;
    assign cpu_nreset = cpu_nreset_reg;

    // State and datapath registers. cpu_nreset rises on the edge that enters RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            len_reg        <= '0;
            index_reg      <= '0;
            word_reg       <= '0;
            byte_cnt_reg   <= '0;
            cpu_nreset_reg <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_reg       <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            len_reg        <= len_next;
            index_reg      <= index_next;
            word_reg       <= word_next;
            byte_cnt_reg   <= byte_cnt_next;
            cpu_nreset_reg <= (state_next == S_RUN);
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_reg       <= csum_next;
`endif
        end
    end

    // Next-state and datapath update: parse the frame one accepted byte at a time.
    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        index_next    = index_reg;
        word_next     = word_reg;
        byte_cnt_next = byte_cnt_reg;
`ifdef BOOT_LOADER_CHECKSUM_EN
        csum_next     = csum_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_next = S_LEN_HI;
`ifdef BOOT_LOADER_CHECKSUM_EN
                    csum_next  = '0;
`endif
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_next[15:8] = rx_data;
                    state_next     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_next[7:0] = rx_data;
                    index_next    = '0;
                    byte_cnt_next = '0;
                    if ({len_reg[15:8], rx_data} == 16'd0)
                        state_next = S_FRAME_END;
                    else
                        state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    // Shift in from the LSB side so the first byte lands in [31:24].
                    word_next     = {word_reg[23:0], rx_data};
                    byte_cnt_next = byte_cnt_reg + 2'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                    csum_next     = csum_reg ^ rx_data;
`endif
                    if (byte_cnt_reg == 2'd3)
                        state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                index_next    = index_reg + 16'd1;
                byte_cnt_next = '0;
                // index never exceeds len-1 here, so the 16-bit sum cannot wrap.
                if (index_reg + 16'd1 == len_reg)
                    state_next = S_FRAME_END;
                else
                    state_next = S_DATA;
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept)
                    state_next = (rx_data == csum_reg) ? S_RUN : S_ERROR;
            end
`endif
            S_RUN:   state_next = S_RUN;
            S_ERROR: state_next = S_ERROR;
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode: byte handshake, status code and the RAM port mux.
    always_comb begin
        rx_ready    = 1'b0;
        status      = 8'h02;
        ram_wren    = 1'b0;
        ram_address = ADDR_W'(index_reg);
        ram_data    = word_reg;
        case (state_reg)
            S_IDLE: begin
                rx_ready = 1'b1;
                status   = 8'h01;
            end
            S_LEN_HI, S_LEN_LO, S_DATA: rx_ready = 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
            S_CSUM: rx_ready = 1'b1;
`endif
            S_WRITE: ram_wren = 1'b1;
            S_RUN: begin
                // The CPU owns the RAM port once loading is done.
                status      = 8'h04;
                ram_wren    = cpu_wren;
                ram_address = cpu_address;
                ram_data    = cpu_data;
            end
            S_ERROR: status = 8'hEE;
            default: status = 8'h02;
        endcase
    end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed and randomized frames for boot_loader. The bench
// keeps its own RAM image (written from the RAM port) and its expected word
// list, and compares the image, write count and reset/status timing.
// Follows BOOT_LOADER_CHECKSUM_EN the same way the design does.
module tb_boot_loader;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [ADDR_W-1:0] cpu_address = '0;
    logic [31:0]       cpu_data = '0;
    logic              cpu_wren = 1'b0;
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_data;
    logic              ram_wren;
    logic              cpu_nreset;
    logic [7:0]        status;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];
    logic [31:0] exp_words [0:255];
    int          wr_count = 0;
    int          dbl_pulse = 0;
    logic        prev_wren = 1'b0;

    boot_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hC0)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_wren(cpu_wren),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .cpu_nreset(cpu_nreset), .status(status)
    );

    always #5 clk = ~clk;

    // Loader-side RAM image; counts write pulses and back-to-back writes.
    always @(posedge clk) begin
        if (ram_wren && !cpu_nreset) begin
            mem[ram_address[7:0]] <= ram_data;
            wr_count <= wr_count + 1;
            if (prev_wren) dbl_pulse <= dbl_pulse + 1;
        end
        prev_wren <= ram_wren && !cpu_nreset;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        for (int g = 0; g < gap; g++) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("byte_accepted", n < 50, 1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Reset with a byte offered meanwhile; nothing may be consumed.
    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        rx_data     = 8'hC0;
        rx_valid    = 1'b1;
        cpu_address = ADDR_W'($urandom);
        cpu_data    = $urandom;
        cpu_wren    = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_status", status, 8'h01);
        check("rst_nreset", cpu_nreset, 0);
        check("rst_rx_ready", rx_ready, 1);
        check("rst_ram_wren", ram_wren, 0);
        check("rst_ram_addr", ram_address, 0);
        check("rst_ram_data", ram_data, 0);
        rx_valid = 1'b0;
        reset    = 1'b0;
        cpu_wren = 1'b0;
        #1;
        check("rst_rel_status", status, 8'h01);
    endtask

    // Send a full frame of exp_words[0..len-1] and check write/run timing and RAM.
    task automatic load_frame(input logic [15:0] len, input int noise, input int max_gap);
        logic [7:0] b;
        logic [7:0] cs;
        int base;
        cs   = 8'h00;
        base = wr_count;
        for (int i = 0; i < noise; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hC0) b = 8'h3C;
            send_byte(b, $urandom_range(0, max_gap));
            check("noise_discard", status, 8'h01);
        end
        send_byte(8'hC0, $urandom_range(0, max_gap));
        check("sync_status", status, 8'h02);
        send_byte(len[15:8], $urandom_range(0, max_gap));
        send_byte(len[7:0], $urandom_range(0, max_gap));
        for (int i = 0; i < int'(len); i++) begin
            for (int k = 0; k < 4; k++) begin
                b = exp_words[i][31-8*k -: 8];
                cs ^= b;
                send_byte(b, $urandom_range(0, max_gap));
            end
            check("load_nreset_low", cpu_nreset, 0);
        end
        if (len != 0) begin
            check("wr_cycle_wren", ram_wren, 1);
            check("wr_cycle_addr", ram_address, len - 16'd1);
            check("wr_cycle_data", ram_data, exp_words[len - 16'd1]);
            check("wr_cycle_rx_ready", rx_ready, 0);
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        send_byte(cs, 0);
`else
        if (len != 0) @(negedge clk);
`endif
        check("run_nreset", cpu_nreset, 1);
        check("run_status", status, 8'h04);
        check("run_rx_ready", rx_ready, 0);
        check("run_ram_wren", ram_wren, cpu_wren);
        check("write_count", wr_count - base, len);
        check("single_pulses", dbl_pulse, 0);
        for (int i = 0; i < int'(len); i++)
            check("ram_word", mem[i], exp_words[i]);
    endtask

    initial begin : stim
        int bad;
        int base;
        logic [15:0] rlen;

        // Directed: two words.
        do_reset();
        exp_words[0] = 32'hDEADBEEF;
        exp_words[1] = 32'h01020304;
        load_frame(16'd2, 0, 0);

        // Junk before sync is discarded.
        do_reset();
        send_byte(8'h55, 0);
        check("junk55_status", status, 8'h01);
        send_byte(8'hAA, 0);
        check("junkAA_status", status, 8'h01);
        exp_words[0] = 32'h11223344;
        load_frame(16'd1, 0, 0);

        // Zero-length frame: straight to RUN with no write.
        do_reset();
        load_frame(16'd0, 0, 0);

        // Reset in the middle of a stalled frame.
        do_reset();
        base = wr_count;
        send_byte(8'hC0, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_nreset !== 1'b0 || ram_wren !== 1'b0) bad++;
        end
        check("stall_quiet", bad, 0);
        check("stall_status", status, 8'h02);
        #3 reset = 1'b1;
        #1;
        check("async_rst_status", status, 8'h01);
        check("async_rst_addr", ram_address, 0);
        check("async_rst_data", ram_data, 0);
        @(negedge clk);
        reset = 1'b0;
        check("aborted_no_write", wr_count - base, 0);
        exp_words[0] = 32'hA1B2C3D4;
        load_frame(16'd1, 0, 0);

        // In RUN the CPU drives the RAM combinationally; rx bytes are refused.
        cpu_address = 16'h0005;
        cpu_data    = 32'hCAFEF00D;
        cpu_wren    = 1'b1;
        rx_data     = 8'hC0;
        rx_valid    = 1'b1;
        #1;
        check("mux_addr", ram_address, 16'h0005);
        check("mux_data", ram_data, 32'hCAFEF00D);
        check("mux_wren", ram_wren, 1);
        check("mux_rx_ready", rx_ready, 0);
        cpu_address = ADDR_W'($urandom);
        cpu_data    = $urandom;
        cpu_wren    = 1'b0;
        #1;
        check("mux_addr_rand", ram_address, cpu_address);
        check("mux_data_rand", ram_data, cpu_data);
        check("mux_wren_low", ram_wren, 0);
        @(negedge clk);
        check("run_holds", status, 8'h04);
        rx_valid = 1'b0;

`ifdef BOOT_LOADER_CHECKSUM_EN
        // Good checksum handled by load_frame; bad one must land in ERROR.
        do_reset();
        exp_words[0] = 32'h01020408;
        load_frame(16'd1, 0, 0);
        do_reset();
        send_byte(8'hC0, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h04, 0);
        send_byte(8'h08, 0);
        send_byte(8'h0E, 0);
        check("csum_bad_status", status, 8'hEE);
        check("csum_bad_nreset", cpu_nreset, 0);
        check("csum_bad_rx_ready", rx_ready, 0);
`endif

        // Randomized frames with junk lead-in and handshake gaps.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            rlen = 16'($urandom_range(1, 8));
            for (int i = 0; i < int'(rlen); i++) exp_words[i] = $urandom;
            load_frame(rlen, $urandom_range(0, 3), 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Sits directly upstream of the CPU core and its program RAM.
- Accepts a byte stream from the serial receiver and assembles big-endian 32-bit words. Writes them to program RAM from address 0 upward, then releases the CPU's active-low reset.
- While loading, the block owns the RAM port. After loading, RAM address/data/wren pass through from the CPU unchanged.

Parameters:
- ADDR_W, 16, RAM address width; equals CPU address bus width.
- SYNC_BYTE, 8'hC0, byte that starts a load frame.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid this cycle
- rx_ready  out  1  block can accept a byte; transfer occurs when rx_valid && rx_ready at posedge clk
- cpu_address  in  ADDR_W  CPU RAM address
- cpu_data  in  32  CPU write data
- cpu_wren  in  1  CPU write enable
- ram_address  out  ADDR_W  to RAM
- ram_data  out  32  to RAM
- ram_wren  out  1  to RAM
- cpu_nreset  out  1  CPU reset, active low, registered
- status  out  8  boot state indicator

Behaviour:
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO, then LEN words of 4 bytes each, MSB first.
  - LEN is a 16-bit word count.
  - With CHECKSUM_EN, one checksum byte follows the last word.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, (CSUM), RUN, ERROR.
- IDLE:
  - rx_ready=1.
  - Accepted byte == SYNC_BYTE -> LEN_HI. Any other byte is discarded and the state stays IDLE.
- LEN_HI / LEN_LO: each accepts one byte into len[15:8] / len[7:0].
  - After LEN_LO: if len==0, go to RUN (or CSUM when enabled); otherwise go to DATA with word index=0 and byte count=0.
- DATA:
  - rx_ready=1. Each accepted byte shifts into word[31:0] from the LSB side, so the first byte ends up in [31:24].
  - On the 4th accepted byte -> WRITE.
  - rx_valid low simply stalls; there is no timeout.
- WRITE: exactly one cycle.
  - rx_ready=0; ram_wren=1, ram_address=index[ADDR_W-1:0], ram_data=word.
  - Then index<=index+1 and byte count<=0.
  - If index+1==len -> RUN (or CSUM); else -> DATA.
- Word-count width: index is 16 bits. len up to 65535 is legal; no address wrap can occur.
- RUN:
  - Terminal until reset; rx_ready=0.
  - cpu_nreset goes to 1 on the clock edge that enters RUN.
  - RAM outputs = CPU inputs, combinationally.
- ERROR: terminal until reset; rx_ready=0; cpu_nreset stays 0.
- RAM mux outside RUN:
  - ram_wren=1 only in WRITE; ram_address=index and ram_data=word in all non-RUN states.
  - CPU inputs are ignored.
- Reset (asynchronous, any time, including mid-frame):
  - State=IDLE; len, index, word and byte count cleared.
  - cpu_nreset=0, status=8'h01.
  - rx_ready decodes as 1 but no byte is consumed while reset is asserted.
  - ram_wren=0, ram_address=0, ram_data=0.
- A partially loaded RAM is not cleared; the next frame overwrites it from address 0.
- status values: IDLE 8'h01; LEN_HI/LEN_LO/DATA/WRITE/CSUM 8'h02; RUN 8'h04; ERROR 8'hEE.
- Latency: last data byte accepted at edge N -> RAM write at edge N+1 -> cpu_nreset=1 from edge N+1 (entering RUN at that edge).

Optional Feature:
- Macro: BOOT_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of every data byte (not SYNC or LEN) is kept; it is cleared on entering LEN_HI.
  - After the last word, or straight after LEN_LO when len==0, the state is CSUM. CSUM accepts one byte.
  - Byte equal to the running XOR -> RUN. Otherwise -> ERROR.
- Not defined: no CSUM state and no checksum register. The frame ends after the last word.

Test Plan:
- Reset, then send C0 00 02 DE AD BE EF 01 02 03 04 -> RAM[0]=DEADBEEF, RAM[1]=01020304, two single-cycle ram_wren pulses, cpu_nreset rises the edge after the last write-cycle edge, status 01->02->04.
- Send 55 AA C0 00 01 11 22 33 44 -> 55 and AA discarded in IDLE; RAM[0]=11223344; RUN.
- Send C0 00 00 -> no ram_wren; RUN immediately (checksum build: needs trailing 00).
- Send C0 00 01 12, gap rx_valid for 20 cycles, assert reset, release, send C0 00 01 A1 B2 C3 D4 -> no write from the first frame; RAM[0]=A1B2C3D4; cpu_nreset low throughout the first attempt.
- In RUN, drive cpu_address=0005, cpu_data=CAFEF00D, cpu_wren=1 -> ram_* mirror the CPU the same cycle; rx_ready=0 with rx_valid=1.
- Checksum build: C0 00 01 01 02 04 08 0F -> RUN. Same frame with trailing 0E -> ERROR, status EE, cpu_nreset=0.
